// File: rtl/mod_clock_scheduler_if.sv
// Run-control and clock-enable bundle of the NES clock scheduler.
//   pause_req/step_req/run_req : one-cycle run-control request pulses (master -> slave)
//   ppu_ce/cpu_ce/apu_ce       : one-cycle subsystem enables (slave -> master)
//   baud_tick                  : free-running UART tick, unaffected by pause
//   paused                     : high while the console is halted
//   cpu_cycle_count            : number of cpu_ce pulses since reset, wrapping
interface mod_clock_scheduler_if;
    logic        pause_req;
    logic        step_req;
    logic        run_req;
    logic        ppu_ce;
    logic        cpu_ce;
    logic        apu_ce;
    logic        baud_tick;
    logic        paused;
    logic [15:0] cpu_cycle_count;

    modport master (
        output pause_req, step_req, run_req,
        input  ppu_ce, cpu_ce, apu_ce, baud_tick, paused, cpu_cycle_count
    );

    modport slave (
        input  pause_req, step_req, run_req,
        output ppu_ce, cpu_ce, apu_ce, baud_tick, paused, cpu_cycle_count
    );
endinterface

// File: rtl/mod_clock_scheduler.sv
// NES timing generator on the pixel clock. A phase accumulator produces the PPU enable;
// the CPU enable is every third PPU enable and the APU enable every second CPU enable.
// A separate accumulator produces the UART baud tick. Run control can halt the console
// on a CPU-cycle boundary, single-step one CPU cycle, and resume with phase intact.
//   clk_in_25_175_mhz : sole clock, rising edge
//   rst_n             : asynchronous active-low reset
//   sched             : slave side of mod_clock_scheduler_if (requests in, enables out)
module mod_clock_scheduler #(
    parameter int unsigned PPU_INC      = 13977,
    parameter int unsigned BAUD_INC     = 300,
    parameter int unsigned ACC_WIDTH    = 16,
    parameter bit          START_PAUSED = 1'b0
) (
    input  logic                 clk_in_25_175_mhz,
    input  logic                 rst_n,
    mod_clock_scheduler_if.slave sched
);
    localparam logic [ACC_WIDTH:0] PpuIncExt  = (ACC_WIDTH + 1)'(PPU_INC);
    localparam logic [ACC_WIDTH:0] BaudIncExt = (ACC_WIDTH + 1)'(BAUD_INC);

    typedef enum logic [1:0] {StRun, StDrain, StPaused, StStep} state_e;

    localparam state_e ResetState = START_PAUSED ? StPaused : StRun;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_ppu_q, acc_ppu_d;
    logic [ACC_WIDTH-1:0] acc_baud_q, acc_baud_d;
    logic [1:0]           cpu_div_q, cpu_div_d;
    logic                 apu_div_q, apu_div_d;
    logic [15:0]          count_q, count_d;
    logic                 ppu_ce_q, cpu_ce_q, apu_ce_q, baud_ce_q, paused_q;

    logic                 advance;
    logic [ACC_WIDTH:0]   ppu_sum, baud_sum;
    logic                 ppu_tick, cpu_tick, apu_tick, baud_tick;

    // Tick conditions, all from current state; the strobes themselves are registered.
    always_comb begin
        advance   = (state_q != StPaused);
        ppu_sum   = {1'b0, acc_ppu_q} + PpuIncExt;
        baud_sum  = {1'b0, acc_baud_q} + BaudIncExt;
        ppu_tick  = advance & ppu_sum[ACC_WIDTH];
        cpu_tick  = ppu_tick & (cpu_div_q == 2'd2);
        apu_tick  = cpu_tick & apu_div_q;
        baud_tick = baud_sum[ACC_WIDTH];
    end

    // Datapath next state; holding everything when !advance keeps the phase across a pause.
    always_comb begin
        acc_ppu_d  = advance ? ppu_sum[ACC_WIDTH-1:0] : acc_ppu_q;
        acc_baud_d = baud_sum[ACC_WIDTH-1:0];
        cpu_div_d  = cpu_div_q;
        if (ppu_tick) begin
            cpu_div_d = (cpu_div_q == 2'd2) ? 2'd0 : cpu_div_q + 2'd1;
        end
        apu_div_d = cpu_tick ? ~apu_div_q : apu_div_q;
        count_d   = count_q + {15'd0, cpu_tick};
    end

    // Run control. DRAIN and STEP both finish on the next CPU tick, so a halt always
    // lands on a CPU-cycle boundary. Requests outside their accepting state are dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (sched.pause_req) begin
                    state_d = cpu_tick ? StPaused : StDrain;
                end
            end
            StDrain: begin
                if (cpu_tick) begin
                    state_d = StPaused;
                end
            end
            StPaused: begin
                if (sched.run_req) begin
                    state_d = StRun;
                end else if (sched.step_req) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                if (cpu_tick) begin
                    state_d = StPaused;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_in_25_175_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ResetState;
            acc_ppu_q  <= '0;
            acc_baud_q <= '0;
            cpu_div_q  <= 2'd0;
            apu_div_q  <= 1'b0;
            count_q    <= 16'd0;
            ppu_ce_q   <= 1'b0;
            cpu_ce_q   <= 1'b0;
            apu_ce_q   <= 1'b0;
            baud_ce_q  <= 1'b0;
            paused_q   <= START_PAUSED;
        end else begin
            state_q    <= state_d;
            acc_ppu_q  <= acc_ppu_d;
            acc_baud_q <= acc_baud_d;
            cpu_div_q  <= cpu_div_d;
            apu_div_q  <= apu_div_d;
            count_q    <= count_d;
            ppu_ce_q   <= ppu_tick;
            cpu_ce_q   <= cpu_tick;
            apu_ce_q   <= apu_tick;
            baud_ce_q  <= baud_tick;
            // Rises together with the final cpu_ce of a drain or step.
            paused_q   <= (state_d == StPaused);
        end
    end

    assign sched.ppu_ce          = ppu_ce_q;
    assign sched.cpu_ce          = cpu_ce_q;
    assign sched.apu_ce          = apu_ce_q;
    assign sched.baud_tick       = baud_ce_q;
    assign sched.paused          = paused_q;
    assign sched.cpu_cycle_count = count_q;
endmodule
